ixu_issue: RTL and testbench
============================

Name: ixu_issue

Overview:
- Operand-read and issue stage that feeds the integer execute unit.
- Accepts decoded integer micro-ops from decode through a valid/ready handshake, and reads rs1/rs2 from the register file.
- Tracks pending destination writes with a scoreboard and forwards same-cycle writeback data.
- Presents a registered operand bundle (rs1_data, rs2_data, imm, is_imm_type, is_nop, op) to execute with a valid/ready handshake.
- Closes the loop with the writeback path, which clears scoreboard entries.

Parameters:
- XLEN, 32, data width of operands and writeback data.
- NREGS, 32, number of architectural integer registers; x0 is hardwired zero.
- ADDR_W, 5, register address width (clog2 NREGS).
- STALL_CNT_W, 16, width of the saturating hazard-stall counter.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  decode presents a micro-op
- in_ready  output  1  issue accepts the micro-op this cycle
- in_rs1  input  ADDR_W  source register 1
- in_rs2  input  ADDR_W  source register 2
- in_rd  input  ADDR_W  destination register
- in_writes_rd  input  1  micro-op writes rd
- in_imm  input  12  raw immediate
- in_is_imm_type  input  1  immediate form; rs2 is not read
- in_is_nop  input  1  bubble/NOP
- in_op  input  4  ALU op code
- rf_rs1_addr  output  ADDR_W  register file read address 1 (= in_rs1)
- rf_rs2_addr  output  ADDR_W  register file read address 2 (= in_rs2)
- rf_rs1_data  input  XLEN  combinational read data 1
- rf_rs2_data  input  XLEN  combinational read data 2
- wb_valid  input  1  writeback retires a result this cycle
- wb_rd  input  ADDR_W  writeback destination
- wb_data  input  XLEN  writeback data
- ex_valid  output  1  operand bundle valid
- ex_ready  input  1  execute consumes the bundle
- ex_rs1_data  output  XLEN  operand X
- ex_rs2_data  output  XLEN  operand Y source
- ex_imm  output  12  immediate
- ex_is_imm_type  output  1  immediate form
- ex_is_nop  output  1  NOP
- ex_op  output  4  ALU op
- ex_rd  output  ADDR_W  destination, carried to writeback
- ex_writes_rd  output  1  writes rd
- stall_cnt  output  STALL_CNT_W  saturating count of hazard-stall cycles
- illegal_op  output  1  sticky flag: an op above 4'h9 was accepted

Behaviour:
- Reset values: ex_valid=0; all ex_* data fields=0; every scoreboard busy bit=0; stall_cnt=0; illegal_op=0. Reset mid-operation discards the held bundle and all pending scoreboard state.
- Output stage has two states: EMPTY (ex_valid=0) and FULL (ex_valid=1).
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on ex_ready with no new accept.
  - FULL -> FULL on ex_ready with a new accept (back-to-back, one op per cycle).
  - While FULL and ex_ready=0, every ex_* output holds stable.
- Operand need: rs1 is needed when !in_is_nop. rs2 is needed when !in_is_nop && !in_is_imm_type. Register x0 is never busy.
- Per-operand hazard: the operand is needed && busy[rs] && !(wb_valid && wb_rd==rs).
- WAW hazard: in_writes_rd && in_rd!=0 && busy[in_rd] && !(wb_valid && wb_rd==in_rd).
- in_ready = no hazard && (!ex_valid || ex_ready). in_ready may depend on in_* fields and wb_*, but never on in_valid.
- Accept = in_valid && in_ready. Latency from accept to ex_valid is exactly 1 cycle.
- Operand select, rs1 (rs2 identical):
  - If rs==0, the operand is 0.
  - Otherwise, if wb_valid && wb_rd==rs, the operand is wb_data (forward).
  - Otherwise, the operand is rf_rs1_data.
  - For operands that are not needed, the operand is 0.
- Scoreboard update at each clock edge:
  - wb_valid clears busy[wb_rd].
  - Accept with in_writes_rd && in_rd!=0 sets busy[in_rd].
  - If both target the same register, set wins.
  - wb_valid with wb_rd==0 or a non-busy rd is a no-op.
- Illegal op: if in_op>4'h9 and !in_is_nop on accept, the bundle is issued with ex_is_nop=1, ex_writes_rd=0, ex_op=in_op, and illegal_op is set. illegal_op clears only on rst.
- NOP: an accepted NOP skips all hazard checks, sets no busy bit, and forces ex_writes_rd=0.
- stall_cnt increments when in_valid && !in_ready because of a hazard. Backpressure-only stalls (ex_valid && !ex_ready with no hazard) are not counted. The counter saturates at all-ones.

Decomposition:
- Package ixu_pkg holds:
  - XLEN and REG_ADDR_W constants.
  - reg_addr_t typedef.
  - ixu_op_t enum: ADD=0, SUB, XOR, OR, AND, SLL, SRL, SRA, SLT, SLTU=9.
  - ixu_uop_t packed struct (rd, writes_rd, imm, is_imm_type, is_nop, op). Used for both the in_* and ex_* bundles.
- Sub-module ixu_scoreboard: busy vector with set/clear ports and set-wins priority, plus per-query busy outputs (rs1, rs2, rd) with writeback bypass. The issue logic and output register stay in ixu_issue.

Test Plan:
- Reset then ADDI x1,x0,5 (rf data ignored), ex_ready=1 -> ex_valid=1 one cycle after accept; ex_rs1_data=0; ex_imm=12'h005; busy[1]=1.
- ADD x2,x1,x1 while busy[1] and no writeback -> in_ready=0, stall_cnt increments each cycle. Then wb_valid, wb_rd=1, wb_data=32'h5 -> accepted that cycle with ex_rs1_data=ex_rs2_data=32'h5 (forward, not rf data).
- Hold ex_ready=0 with a FULL stage, toggling in_* -> ex_* stable and in_ready=0, stall_cnt unchanged. Raise ex_ready -> next op issues the following cycle.
- Same cycle: wb_rd=3 clears while an accepted op has rd=3 -> busy[3]=1 afterward (set wins).
- Accept op=4'hB -> ex_is_nop=1, ex_writes_rd=0, illegal_op=1 sticky; no busy bit set.
- Assert rst while FULL with busy bits set -> ex_valid=0, scoreboard clear and stall_cnt=0 immediately, without a clock edge.

Source files
------------

// File: rtl/ixu_pkg.sv
`default_nettype none
// ============================================================================
// ixu_pkg : shared types and constants for the integer issue stage
// Rev 1.0
// ============================================================================
package ixu_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        XOR  = 4'd2,
        OR   = 4'd3,
        AND  = 4'd4,
        SLL  = 4'd5,
        SRL  = 4'd6,
        SRA  = 4'd7,
        SLT  = 4'd8,
        SLTU = 4'd9
    } ixu_op_t;

    // op is kept as raw bits so undefined encodings can travel to execute
    typedef struct packed {
        reg_addr_t   rd;
        logic        writes_rd;
        logic [11:0] imm;
        logic        is_imm_type;
        logic        is_nop;
        logic [3:0]  op;
    } ixu_uop_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        return op <= 4'(SLTU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ixu_scoreboard.sv
`default_nettype none
// ============================================================================
// ixu_scoreboard : pending-write busy vector with set-wins update and
//                  writeback-bypassed busy queries
// Rev 1.0
// ============================================================================
module ixu_scoreboard #(
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_rd,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_rd,
    input  logic [ADDR_W-1:0] q_rs1,
    input  logic [ADDR_W-1:0] q_rs2,
    input  logic [ADDR_W-1:0] q_rd,
    output logic              busy_rs1,
    output logic              busy_rs2,
    output logic              busy_rd
);
    import ixu_pkg::*;

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_set_mask;
    logic [NREGS-1:0] w_clr_mask;

    assign w_set_mask = set_en ? (NREGS'(1) << set_rd) : '0;
    assign w_clr_mask = clr_en ? (NREGS'(1) << clr_rd) : '0;

    // set is OR-ed in after the clear so a same-register collision stays busy;
    // bit 0 is masked so x0 can never become busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= ((r_busy & ~w_clr_mask) | w_set_mask) & ~NREGS'(1);
        end
    end

    assign busy_rs1 = r_busy[q_rs1] && !(clr_en && clr_rd == q_rs1);
    assign busy_rs2 = r_busy[q_rs2] && !(clr_en && clr_rd == q_rs2);
    assign busy_rd  = r_busy[q_rd]  && !(clr_en && clr_rd == q_rd);

endmodule
`default_nettype wire

// File: rtl/ixu_issue.sv
`default_nettype none
// ============================================================================
// ixu_issue : operand-read / issue stage feeding the integer execute unit
// Rev 1.0
// ============================================================================
module ixu_issue #(
    parameter int XLEN        = 32,
    parameter int NREGS       = 32,
    parameter int ADDR_W      = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDR_W-1:0]      in_rs1,
    input  logic [ADDR_W-1:0]      in_rs2,
    input  logic [ADDR_W-1:0]      in_rd,
    input  logic                   in_writes_rd,
    input  logic [11:0]            in_imm,
    input  logic                   in_is_imm_type,
    input  logic                   in_is_nop,
    input  logic [3:0]             in_op,
    output logic [ADDR_W-1:0]      rf_rs1_addr,
    output logic [ADDR_W-1:0]      rf_rs2_addr,
    input  logic [XLEN-1:0]        rf_rs1_data,
    input  logic [XLEN-1:0]        rf_rs2_data,
    input  logic                   wb_valid,
    input  logic [ADDR_W-1:0]      wb_rd,
    input  logic [XLEN-1:0]        wb_data,
    output logic                   ex_valid,
    input  logic                   ex_ready,
    output logic [XLEN-1:0]        ex_rs1_data,
    output logic [XLEN-1:0]        ex_rs2_data,
    output logic [11:0]            ex_imm,
    output logic                   ex_is_imm_type,
    output logic                   ex_is_nop,
    output logic [3:0]             ex_op,
    output logic [ADDR_W-1:0]      ex_rd,
    output logic                   ex_writes_rd,
    output logic [STALL_CNT_W-1:0] stall_cnt,
    output logic                   illegal_op
);
    import ixu_pkg::*;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    out_state_e             r_state;
    out_state_e             w_state_nxt;
    ixu_uop_t               r_uop;
    logic [XLEN-1:0]        r_rs1_data;
    logic [XLEN-1:0]        r_rs2_data;
    logic [STALL_CNT_W-1:0] r_stall_cnt;
    logic                   r_illegal;

    logic w_need_rs1, w_need_rs2;
    logic w_busy_rs1, w_busy_rs2, w_busy_rd;
    logic w_hazard, w_room, w_accept, w_illegal, w_sets_rd;
    logic [XLEN-1:0] w_rs1_val, w_rs2_val;
    ixu_uop_t w_uop;

    assign rf_rs1_addr = in_rs1;
    assign rf_rs2_addr = in_rs2;

    assign w_need_rs1 = !in_is_nop;
    assign w_need_rs2 = !in_is_nop && !in_is_imm_type;
    assign w_illegal  = !in_is_nop && !op_is_legal(in_op);

    // a NOP carries no dependencies, so it bypasses every hazard term
    assign w_hazard = (w_need_rs1 && w_busy_rs1)
                    || (w_need_rs2 && w_busy_rs2)
                    || (!in_is_nop && in_writes_rd && (in_rd != '0) && w_busy_rd);
    assign w_room   = !ex_valid || ex_ready;
    assign in_ready = !w_hazard && w_room;
    assign w_accept = in_valid && in_ready;
    assign w_sets_rd = w_accept && in_writes_rd && (in_rd != '0) && !in_is_nop && !w_illegal;

    ixu_scoreboard #(
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (w_sets_rd),
        .set_rd   (in_rd),
        .clr_en   (wb_valid),
        .clr_rd   (wb_rd),
        .q_rs1    (in_rs1),
        .q_rs2    (in_rs2),
        .q_rd     (in_rd),
        .busy_rs1 (w_busy_rs1),
        .busy_rs2 (w_busy_rs2),
        .busy_rd  (w_busy_rd)
    );

    function automatic logic [XLEN-1:0] pick_operand(
        input logic              need,
        input logic [ADDR_W-1:0] rs,
        input logic [XLEN-1:0]   rf_data
    );
        if (!need || rs == '0) begin
            return '0;
        end else if (wb_valid && wb_rd == rs) begin
            return wb_data;
        end
        return rf_data;
    endfunction

    assign w_rs1_val = pick_operand(w_need_rs1, in_rs1, rf_rs1_data);
    assign w_rs2_val = pick_operand(w_need_rs2, in_rs2, rf_rs2_data);

    always_comb begin
        w_uop             = '0;
        w_uop.rd          = in_rd;
        w_uop.writes_rd   = in_writes_rd && !in_is_nop && !w_illegal;
        w_uop.imm         = in_imm;
        w_uop.is_imm_type = in_is_imm_type;
        w_uop.is_nop      = in_is_nop || w_illegal;
        w_uop.op          = in_op;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
            ST_FULL:  if (!w_accept && ex_ready) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_uop      <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
        end else if (w_accept) begin
            r_uop      <= w_uop;
            r_rs1_data <= w_rs1_val;
            r_rs2_data <= w_rs2_val;
        end
    end

    // only dependency stalls are counted; pure backpressure is not
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_illegal   <= 1'b0;
        end else begin
            if (in_valid && w_hazard && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
            end
            if (w_accept && w_illegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    assign ex_valid       = (r_state == ST_FULL);
    assign ex_rs1_data    = r_rs1_data;
    assign ex_rs2_data    = r_rs2_data;
    assign ex_imm         = r_uop.imm;
    assign ex_is_imm_type = r_uop.is_imm_type;
    assign ex_is_nop      = r_uop.is_nop;
    assign ex_op          = r_uop.op;
    assign ex_rd          = r_uop.rd;
    assign ex_writes_rd   = r_uop.writes_rd;
    assign stall_cnt      = r_stall_cnt;
    assign illegal_op     = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_ixu_issue.sv
`default_nettype none
// ============================================================================
// tb_ixu_issue : directed vector table plus randomized run against a
//                behavioural model of the issue stage
// Rev 1.0
// ============================================================================
module tb_ixu_issue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid, in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_writes_rd, in_is_imm_type, in_is_nop;
    logic [11:0] in_imm;
    logic [3:0]  in_op;
    logic [4:0]  rf_rs1_addr, rf_rs2_addr;
    logic [31:0] rf_rs1_data, rf_rs2_data;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_rs1_data, ex_rs2_data;
    logic [11:0] ex_imm;
    logic        ex_is_imm_type, ex_is_nop, ex_writes_rd;
    logic [3:0]  ex_op;
    logic [4:0]  ex_rd;
    logic [15:0] stall_cnt;
    logic        illegal_op;

    logic [31:0] rf_mem [32];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign rf_rs1_data = rf_mem[rf_rs1_addr];
    assign rf_rs2_data = rf_mem[rf_rs2_addr];

    ixu_issue dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_writes_rd(in_writes_rd), .in_imm(in_imm),
        .in_is_imm_type(in_is_imm_type), .in_is_nop(in_is_nop), .in_op(in_op),
        .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_is_imm_type(ex_is_imm_type), .ex_is_nop(ex_is_nop),
        .ex_op(ex_op), .ex_rd(ex_rd), .ex_writes_rd(ex_writes_rd),
        .stall_cnt(stall_cnt), .illegal_op(illegal_op)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic        v;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        wr;
        logic [11:0] imm;
        logic        isimm;
        logic        nop;
        logic [3:0]  op;
        logic        wbv;
        logic [4:0]  wbrd;
        logic [31:0] wbd;
        logic        exr;
        logic        e_rdy;
        logic        e_vld;
        logic [31:0] e_a;
        logic [31:0] e_b;
        logic [11:0] e_imm;
        logic        e_nop;
        logic        e_wr;
        logic [15:0] e_stall;
        logic        e_ill;
    } vec_t;

    localparam int NVEC = 13;
    localparam logic [31:0] RFB = 32'hA000_0000;
    vec_t tbl [NVEC];

    // behavioural model state
    bit          m_busy [32];
    bit          m_valid;
    logic [31:0] m_a, m_b;
    logic [23:0] m_misc;
    logic [15:0] m_stall;
    bit          m_ill;

    function automatic bit fwd(input logic [4:0] r);
        return wb_valid && wb_rd == r;
    endfunction

    function automatic bit eff_busy(input logic [4:0] r);
        return (r != 0) && m_busy[r] && !fwd(r);
    endfunction

    function automatic logic [31:0] opnd(input logic [4:0] r, input bit need, input logic [31:0] d);
        if (!need || r == 0) return 32'h0;
        if (fwd(r)) return wb_data;
        return d;
    endfunction

    task automatic drive(input vec_t t);
        in_valid       = t.v;
        in_rs1         = t.rs1;
        in_rs2         = t.rs2;
        in_rd          = t.rd;
        in_writes_rd   = t.wr;
        in_imm         = t.imm;
        in_is_imm_type = t.isimm;
        in_is_nop      = t.nop;
        in_op          = t.op;
        wb_valid       = t.wbv;
        wb_rd          = t.wbrd;
        wb_data        = t.wbd;
        ex_ready       = t.exr;
    endtask

    initial begin
        vec_t idle;
        idle = '0;
        drive(idle);
        for (int i = 0; i < 32; i++) rf_mem[i] = RFB + 32'(i);
        rf_mem[0] = 32'hDEAD_BEEF;

        //           v rs1 rs2 rd wr imm     im nop op    wbv wbrd wbd    exr rdy vld a       b       e_imm   nop wr stl ill
        tbl[0]  = '{1, 0, 0, 1, 1, 12'h005, 1, 0, 4'h0, 0, 0, 32'h0, 1, 1, 1, 32'h0,  32'h0,  12'h005, 0, 1, 0, 0};
        tbl[1]  = '{1, 1, 1, 2, 1, 12'h000, 0, 0, 4'h0, 0, 0, 32'h0, 1, 0, 0, 32'h0,  32'h0,  12'h000, 0, 0, 1, 0};
        tbl[2]  = '{1, 1, 1, 2, 1, 12'h000, 0, 0, 4'h0, 0, 0, 32'h0, 1, 0, 0, 32'h0,  32'h0,  12'h000, 0, 0, 2, 0};
        tbl[3]  = '{1, 1, 1, 2, 1, 12'h000, 0, 0, 4'h0, 1, 1, 32'h5, 1, 1, 1, 32'h5,  32'h5,  12'h000, 0, 1, 2, 0};
        tbl[4]  = '{1, 0, 0, 4, 1, 12'h007, 1, 0, 4'h0, 0, 0, 32'h0, 0, 0, 1, 32'h5,  32'h5,  12'h000, 0, 1, 2, 0};
        tbl[5]  = '{1, 6, 7, 5, 1, 12'h03C, 0, 0, 4'h3, 0, 0, 32'h0, 0, 0, 1, 32'h5,  32'h5,  12'h000, 0, 1, 2, 0};
        tbl[6]  = '{1, 0, 0, 4, 1, 12'h007, 1, 0, 4'h0, 0, 0, 32'h0, 1, 1, 1, 32'h0,  32'h0,  12'h007, 0, 1, 2, 0};
        tbl[7]  = '{1, 0, 0, 3, 1, 12'h001, 1, 0, 4'h0, 0, 0, 32'h0, 1, 1, 1, 32'h0,  32'h0,  12'h001, 0, 1, 2, 0};
        tbl[8]  = '{1, 0, 0, 3, 1, 12'h002, 1, 0, 4'h0, 1, 3, 32'h9, 1, 1, 1, 32'h0,  32'h0,  12'h002, 0, 1, 2, 0};
        tbl[9]  = '{1, 3, 0, 8, 1, 12'h000, 0, 0, 4'h0, 0, 0, 32'h0, 1, 0, 0, 32'h0,  32'h0,  12'h000, 0, 0, 3, 0};
        tbl[10] = '{1, 5, 6, 9, 1, 12'h0AB, 0, 0, 4'hB, 0, 0, 32'h0, 1, 1, 1, RFB+5,  RFB+6,  12'h0AB, 1, 0, 3, 1};
        tbl[11] = '{1, 9, 0,10, 1, 12'h000, 0, 0, 4'h0, 0, 0, 32'h0, 1, 1, 1, RFB+9,  32'h0,  12'h000, 0, 1, 3, 1};
        tbl[12] = '{1, 3, 3, 3, 1, 12'h000, 0, 1, 4'h0, 0, 0, 32'h0, 1, 1, 1, 32'h0,  32'h0,  12'h000, 1, 0, 3, 1};

        #12;
        chk("reset ex_valid", 32'(ex_valid), 32'h0);
        chk("reset stall_cnt", 32'(stall_cnt), 32'h0);
        chk("reset illegal_op", 32'(illegal_op), 32'h0);
        chk("reset ex_rs1_data", ex_rs1_data, 32'h0);
        chk("reset ex fields", {ex_rs2_data[7:0], ex_imm, ex_op, ex_rd, ex_is_nop, ex_writes_rd, ex_is_imm_type},
            32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i]);
            #1;
            chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
            @(posedge clk); #1;
            chk($sformatf("vec%0d ex_valid", i), 32'(ex_valid), 32'(tbl[i].e_vld));
            if (tbl[i].e_vld) begin
                chk($sformatf("vec%0d ex_rs1_data", i), ex_rs1_data, tbl[i].e_a);
                chk($sformatf("vec%0d ex_rs2_data", i), ex_rs2_data, tbl[i].e_b);
                chk($sformatf("vec%0d ex_imm", i), 32'(ex_imm), 32'(tbl[i].e_imm));
                chk($sformatf("vec%0d nop/wr", i), {30'h0, ex_is_nop, ex_writes_rd},
                    {30'h0, tbl[i].e_nop, tbl[i].e_wr});
            end
            chk($sformatf("vec%0d stall_cnt", i), 32'(stall_cnt), 32'(tbl[i].e_stall));
            chk($sformatf("vec%0d illegal_op", i), 32'(illegal_op), 32'(tbl[i].e_ill));
        end

        // x2, x3, x4, x10 still pending; x1 was retired
        chk("busy vector before reset", dut.u_sb.r_busy, 32'h0000_041C);

        // asynchronous reset between edges while FULL with pending writes
        #2;
        rst = 1'b1;
        #1;
        chk("async rst ex_valid", 32'(ex_valid), 32'h0);
        chk("async rst stall_cnt", 32'(stall_cnt), 32'h0);
        chk("async rst busy", dut.u_sb.r_busy, 32'h0);
        chk("async rst illegal_op", 32'(illegal_op), 32'h0);
        chk("async rst ex_rs1_data", ex_rs1_data, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 32; i++) m_busy[i] = 0;
        m_valid = 0; m_a = 0; m_b = 0; m_misc = 0; m_stall = 0; m_ill = 0;

        for (int it = 0; it < 1500; it++) begin
            bit          need1, need2, haz, exp_rdy, acc, bad;
            logic [31:0] na, nb;

            rf_mem[$urandom_range(0, 31)] = $urandom;
            in_valid       = ($urandom_range(0, 7) != 0);
            in_rs1         = 5'($urandom_range(0, 7));
            in_rs2         = 5'($urandom_range(0, 7));
            in_rd          = 5'($urandom_range(0, 7));
            in_writes_rd   = ($urandom_range(0, 3) != 0);
            in_imm         = 12'($urandom);
            in_is_imm_type = $urandom_range(0, 1) == 1;
            in_is_nop      = ($urandom_range(0, 7) == 0);
            in_op          = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                          : 4'($urandom_range(0, 9));
            wb_valid       = $urandom_range(0, 1) == 1;
            wb_rd          = 5'($urandom_range(0, 7));
            wb_data        = $urandom;
            ex_ready       = ($urandom_range(0, 3) != 0);

            need1   = !in_is_nop;
            need2   = !in_is_nop && !in_is_imm_type;
            haz     = !in_is_nop && ((need1 && eff_busy(in_rs1)) || (need2 && eff_busy(in_rs2))
                                     || (in_writes_rd && eff_busy(in_rd)));
            exp_rdy = !haz && (!m_valid || ex_ready);
            acc     = in_valid && exp_rdy;
            bad     = !in_is_nop && (in_op > 4'h9);
            na      = opnd(in_rs1, need1, rf_mem[in_rs1]);
            nb      = opnd(in_rs2, need2, rf_mem[in_rs2]);

            #1;
            chk("rand in_ready", 32'(in_ready), 32'(exp_rdy));
            @(posedge clk);

            if (wb_valid) m_busy[wb_rd] = 0;
            if (acc && in_writes_rd && in_rd != 0 && !in_is_nop && !bad) m_busy[in_rd] = 1;
            if (in_valid && haz && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
            if (acc && bad) m_ill = 1;
            if (acc) begin
                m_valid = 1;
                m_a     = na;
                m_b     = nb;
                m_misc  = {in_imm, in_is_imm_type, in_is_nop || bad, in_op, in_rd,
                           in_writes_rd && !in_is_nop && !bad};
            end else if (ex_ready) begin
                m_valid = 0;
            end

            #1;
            chk("rand ex_valid", 32'(ex_valid), 32'(m_valid));
            if (m_valid) begin
                chk("rand ex_rs1_data", ex_rs1_data, m_a);
                chk("rand ex_rs2_data", ex_rs2_data, m_b);
                chk("rand ex bundle", 32'({ex_imm, ex_is_imm_type, ex_is_nop, ex_op, ex_rd, ex_writes_rd}),
                    32'(m_misc));
            end
            chk("rand stall_cnt", 32'(stall_cnt), 32'(m_stall));
            chk("rand illegal_op", 32'(illegal_op), 32'(m_ill));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
